mcpu_mem_responder: RTL and testbench

Memory-side responder for the core's two `mem2dc` data ports. It arbitrates the two ports onto one synchronous SRAM port and one MMIO peripheral port, and generates a one-cycle `mem2dc_doneN` with read data for each request. Accesses to the MMIO port may stall or time out. It sits between `MCPU_core` and the on-chip RAM / `MCPU_SOC_mmio`, replacing ad-hoc done generation in SoC tops.

---
 rtl/mcpu_mem_pkg.sv | 37 +++
 rtl/mcpu_mem_responder_if.sv | 62 ++++++
 rtl/mcpu_mem_arb.sv | 42 ++++
 rtl/mcpu_mem_responder.sv | 163 ++++++++++++++++
 tb/tb_mcpu_mem_responder.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mcpu_mem_pkg.sv
// Shared types and constants for the mem2dc responder.
package mcpu_mem_pkg;

  localparam int unsigned PADDR_W      = 30;
  localparam int unsigned MMIO_AW      = 29;
  localparam int unsigned DATA_W       = 32;
  localparam int unsigned BE_W         = 4;
  localparam int unsigned MMIO_SEL_BIT = 29;

  localparam logic [DATA_W-1:0] MMIO_ERR_DATA = 32'hDEAD_BEEF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SRAM_ACC,
    ST_SRAM_CAP,
    ST_MMIO_ACC,
    ST_RESP
  } mem_state_e;

  // One requester's payload as seen at the arbitration point.
  typedef struct packed {
    logic [PADDR_W-1:0] paddr;
    logic [BE_W-1:0]    byteen;
    logic [DATA_W-1:0]  wdata;
  } mem_req_t;

  function automatic logic is_mmio(input logic [PADDR_W-1:0] paddr);
    return paddr[MMIO_SEL_BIT];
  endfunction

  // Writes complete with zero read data; reads return the sampled word.
  function automatic logic [DATA_W-1:0] rd_or_zero(input logic [BE_W-1:0] be,
                                                   input logic [DATA_W-1:0] d);
    return (be != '0) ? '0 : d;
  endfunction

endpackage

// File: rtl/mcpu_mem_responder_if.sv
// Requester, SRAM and MMIO signals of the responder, grouped as one bus.
interface mcpu_mem_responder_if #(
  parameter int unsigned SRAM_AW = 14
);
  import mcpu_mem_pkg::*;

  logic                mem2dc_valid0;
  logic [PADDR_W-1:0]  mem2dc_paddr0;
  logic [BE_W-1:0]     mem2dc_write0;
  logic [DATA_W-1:0]   mem2dc_data_out0;
  logic                mem2dc_done0;
  logic [DATA_W-1:0]   mem2dc_data_in0;

  logic                mem2dc_valid1;
  logic [PADDR_W-1:0]  mem2dc_paddr1;
  logic [BE_W-1:0]     mem2dc_write1;
  logic [DATA_W-1:0]   mem2dc_data_out1;
  logic                mem2dc_done1;
  logic [DATA_W-1:0]   mem2dc_data_in1;

  logic                sram_en;
  logic [SRAM_AW-1:0]  sram_addr;
  logic [BE_W-1:0]     sram_byteen;
  logic [DATA_W-1:0]   sram_wdata;
  logic [DATA_W-1:0]   sram_q;

  logic                mmio_valid;
  logic [MMIO_AW-1:0]  mmio_addr;
  logic [BE_W-1:0]     mmio_byteen;
  logic [DATA_W-1:0]   mmio_wdata;
  logic                mmio_ready;
  logic [DATA_W-1:0]   mmio_rdata;

  logic                bus_err;

  // Environment side: core requesters plus the SRAM and MMIO devices.
  modport master (
    output mem2dc_valid0, mem2dc_paddr0, mem2dc_write0, mem2dc_data_out0,
    input  mem2dc_done0, mem2dc_data_in0,
    output mem2dc_valid1, mem2dc_paddr1, mem2dc_write1, mem2dc_data_out1,
    input  mem2dc_done1, mem2dc_data_in1,
    input  sram_en, sram_addr, sram_byteen, sram_wdata,
    output sram_q,
    input  mmio_valid, mmio_addr, mmio_byteen, mmio_wdata,
    output mmio_ready, mmio_rdata,
    input  bus_err
  );

  // Responder side.
  modport slave (
    input  mem2dc_valid0, mem2dc_paddr0, mem2dc_write0, mem2dc_data_out0,
    output mem2dc_done0, mem2dc_data_in0,
    input  mem2dc_valid1, mem2dc_paddr1, mem2dc_write1, mem2dc_data_out1,
    output mem2dc_done1, mem2dc_data_in1,
    output sram_en, sram_addr, sram_byteen, sram_wdata,
    input  sram_q,
    output mmio_valid, mmio_addr, mmio_byteen, mmio_wdata,
    input  mmio_ready, mmio_rdata,
    output bus_err
  );

endinterface

// File: rtl/mcpu_mem_arb.sv
// Two-port fixed-priority arbiter (port 0 wins) with a starvation escape
// that hands port 1 the grant after STARVE_LIMIT back-to-back port-0 wins.
module mcpu_mem_arb
  import mcpu_mem_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic valid0,
  input  logic valid1,
  input  logic idle,
  output logic grant,
  output logic grant_valid
);

  localparam int unsigned CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_cnt;
  logic             starve_hit;

  // Grant decision; only meaningful while the responder is idle.
  always_comb begin
    starve_hit  = (starve_cnt == CNT_W'(STARVE_LIMIT));
    grant_valid = idle & (valid0 | valid1);
    grant       = valid1 & (~valid0 | starve_hit);
  end

  // Count consecutive port-0 wins over a waiting port 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (idle) begin
      if (valid0 && valid1 && !starve_hit) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end else begin
        starve_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/mcpu_mem_responder.sv
// Memory-side responder: arbitrates the two mem2dc ports onto one SRAM port
// and one MMIO port and returns a single-cycle done with read data.
module mcpu_mem_responder
  import mcpu_mem_pkg::*;
#(
  parameter int unsigned SRAM_AW      = 14,
  parameter int unsigned MMIO_TIMEOUT = 255,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                clkrst_core_clk,
  input  logic                clkrst_core_rst,
  mcpu_mem_responder_if.slave bus
);

  localparam int unsigned WAIT_W = (MMIO_TIMEOUT < 1) ? 1 : $clog2(MMIO_TIMEOUT + 1);

  mem_state_e        state;
  mem_req_t          sel_req;
  logic [BE_W-1:0]   req_be;
  logic              gnt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              mmio_fin;
  logic              err_flag;
  logic [DATA_W-1:0] rdata;
  logic              idle;
  logic              grant;
  logic              grant_valid;

  assign idle = (state == ST_IDLE);

  mcpu_mem_arb #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_arb (
    .clk         (clkrst_core_clk),
    .rst         (clkrst_core_rst),
    .valid0      (bus.mem2dc_valid0),
    .valid1      (bus.mem2dc_valid1),
    .idle        (idle),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  // Payload of whichever port the arbiter currently selects.
  always_comb begin
    sel_req = '0;
    if (grant) begin
      sel_req = '{paddr: bus.mem2dc_paddr1, byteen: bus.mem2dc_write1,
                  wdata: bus.mem2dc_data_out1};
    end else begin
      sel_req = '{paddr: bus.mem2dc_paddr0, byteen: bus.mem2dc_write0,
                  wdata: bus.mem2dc_data_out0};
    end
  end

  // Access sequencer; every bus output is a register.
  // MMIO completions spend one extra MMIO_ACC cycle (mmio_fin) with the
  // request already dropped, so done lands two cycles after mmio_ready.
  always_ff @(posedge clkrst_core_clk) begin
    if (clkrst_core_rst) begin
      state                <= ST_IDLE;
      req_be               <= '0;
      gnt                  <= 1'b0;
      wait_cnt             <= '0;
      mmio_fin             <= 1'b0;
      err_flag             <= 1'b0;
      rdata                <= '0;
      bus.mem2dc_done0     <= 1'b0;
      bus.mem2dc_done1     <= 1'b0;
      bus.mem2dc_data_in0  <= '0;
      bus.mem2dc_data_in1  <= '0;
      bus.sram_en          <= 1'b0;
      bus.sram_addr        <= '0;
      bus.sram_byteen      <= '0;
      bus.sram_wdata       <= '0;
      bus.mmio_valid       <= 1'b0;
      bus.mmio_addr        <= '0;
      bus.mmio_byteen      <= '0;
      bus.mmio_wdata       <= '0;
      bus.bus_err          <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_valid) begin
            gnt    <= grant;
            req_be <= sel_req.byteen;
            if (is_mmio(sel_req.paddr)) begin
              bus.mmio_valid  <= 1'b1;
              bus.mmio_addr   <= sel_req.paddr[MMIO_AW-1:0];
              bus.mmio_byteen <= sel_req.byteen;
              bus.mmio_wdata  <= sel_req.wdata;
              wait_cnt        <= '0;
              state           <= ST_MMIO_ACC;
            end else begin
              bus.sram_en     <= 1'b1;
              bus.sram_addr   <= sel_req.paddr[SRAM_AW-1:0];
              bus.sram_byteen <= sel_req.byteen;
              bus.sram_wdata  <= sel_req.wdata;
              state           <= ST_SRAM_ACC;
            end
          end
        end

        ST_SRAM_ACC: begin
          bus.sram_en <= 1'b0;
          state       <= ST_SRAM_CAP;
        end

        ST_SRAM_CAP: begin
          rdata <= rd_or_zero(req_be, bus.sram_q);
          if (gnt) begin
            bus.mem2dc_done1    <= 1'b1;
            bus.mem2dc_data_in1 <= rd_or_zero(req_be, bus.sram_q);
          end else begin
            bus.mem2dc_done0    <= 1'b1;
            bus.mem2dc_data_in0 <= rd_or_zero(req_be, bus.sram_q);
          end
          state <= ST_RESP;
        end

        ST_MMIO_ACC: begin
          if (mmio_fin) begin
            mmio_fin    <= 1'b0;
            bus.bus_err <= err_flag;
            if (gnt) begin
              bus.mem2dc_done1    <= 1'b1;
              bus.mem2dc_data_in1 <= rdata;
            end else begin
              bus.mem2dc_done0    <= 1'b1;
              bus.mem2dc_data_in0 <= rdata;
            end
            state <= ST_RESP;
          end else if (bus.mmio_ready) begin
            rdata          <= rd_or_zero(req_be, bus.mmio_rdata);
            bus.mmio_valid <= 1'b0;
            wait_cnt       <= '0;
            mmio_fin       <= 1'b1;
          end else if (wait_cnt == WAIT_W'(MMIO_TIMEOUT - 1)) begin
            rdata          <= MMIO_ERR_DATA;
            err_flag       <= 1'b1;
            bus.mmio_valid <= 1'b0;
            wait_cnt       <= '0;
            mmio_fin       <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end

        ST_RESP: begin
          bus.mem2dc_done0 <= 1'b0;
          bus.mem2dc_done1 <= 1'b0;
          bus.bus_err      <= 1'b0;
          err_flag         <= 1'b0;
          state            <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mcpu_mem_responder.sv
// Self-checking bench for mcpu_mem_responder: directed steps from the test
// plan followed by randomized traffic checked against a word-level model.
module tb_mcpu_mem_responder;

  localparam int AW = 14;
  localparam int TO = 255;
  localparam int SL = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  bit [31:0] ref_mem [0:(1<<AW)-1];
  bit [31:0] env_mem [0:(1<<AW)-1];

  always #5 clk = ~clk;

  mcpu_mem_responder_if #(.SRAM_AW(AW)) bus ();

  mcpu_mem_responder #(
    .SRAM_AW      (AW),
    .MMIO_TIMEOUT (TO),
    .STARVE_LIMIT (SL)
  ) dut (
    .clkrst_core_clk (clk),
    .clkrst_core_rst (rst),
    .bus             (bus)
  );

  // Synchronous SRAM device: read data one cycle after sram_en.
  always @(posedge clk) begin
    if (bus.sram_en) begin
      bus.sram_q <= env_mem[bus.sram_addr];
      for (int b = 0; b < 4; b++)
        if (bus.sram_byteen[b]) env_mem[bus.sram_addr][8*b +: 8] <= bus.sram_wdata[8*b +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit [31:0] merge(input bit [31:0] old, input logic [3:0] be,
                                      input logic [31:0] d);
    bit [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic done_of(input int p);
    return (p == 0) ? bus.mem2dc_done0 : bus.mem2dc_done1;
  endfunction

  function automatic logic [31:0] data_of(input int p);
    return (p == 0) ? bus.mem2dc_data_in0 : bus.mem2dc_data_in1;
  endfunction

  task automatic drive(input int p, input logic v, input logic [29:0] a,
                       input logic [3:0] be, input logic [31:0] d);
    if (p == 0) begin
      bus.mem2dc_valid0 = v; bus.mem2dc_paddr0 = a;
      bus.mem2dc_write0 = be; bus.mem2dc_data_out0 = d;
    end else begin
      bus.mem2dc_valid1 = v; bus.mem2dc_paddr1 = a;
      bus.mem2dc_write1 = be; bus.mem2dc_data_out1 = d;
    end
  endtask

  // One request from idle; rdy_dly < 0 means the MMIO device never answers.
  task automatic do_req(input int p, input logic [29:0] a, input logic [3:0] be,
                        input logic [31:0] d, input int rdy_dly, input logic [31:0] mrd);
    logic        mm;
    logic        exp_err;
    logic [31:0] exp_data;
    logic [31:0] other_before;
    int          exp_lat;
    int          last_v;
    int          c;
    int          idx;
    bit          seen;
    bit          dbl;
    bit          vbad;
    bit          ebad;
    mm           = a[29];
    idx          = int'(a[AW-1:0]);
    other_before = data_of(1 - p);
    if (!mm) begin
      exp_lat  = 3;
      last_v   = 0;
      exp_err  = 1'b0;
      exp_data = (be != 4'h0) ? 32'h0 : ref_mem[idx];
      if (be != 4'h0) ref_mem[idx] = merge(ref_mem[idx], be, d);
    end else if (rdy_dly < 0) begin
      exp_lat  = TO + 2;
      last_v   = TO;
      exp_err  = 1'b1;
      exp_data = 32'hDEAD_BEEF;
    end else begin
      exp_lat  = rdy_dly + 3;
      last_v   = rdy_dly + 1;
      exp_err  = 1'b0;
      exp_data = (be != 4'h0) ? 32'h0 : mrd;
    end
    drive(p, 1'b1, a, be, d);
    c = 0; seen = 0; dbl = 0; vbad = 0; ebad = 0;
    while (!seen && c < exp_lat + 10) begin
      tick();
      c++;
      bus.mmio_ready = 1'b0;
      if (mm && rdy_dly >= 0 && c == rdy_dly + 1) begin
        bus.mmio_ready = 1'b1;
        bus.mmio_rdata = mrd;
      end
      if (done_of(1 - p)) dbl = 1;
      if (mm && (bus.mmio_valid !== (c <= last_v))) vbad = 1;
      if (mm && bus.mmio_valid && (bus.mmio_addr !== a[28:0])) vbad = 1;
      if (mm && bus.sram_en) vbad = 1;
      if (!mm && (bus.sram_en !== (c == 1))) vbad = 1;
      if (!mm && bus.mmio_valid) vbad = 1;
      if (c == 1) begin
        if (mm) begin
          chk("mmio_byteen", 32'(bus.mmio_byteen), 32'(be));
          chk("mmio_wdata", bus.mmio_wdata, d);
        end else begin
          chk("sram_addr", 32'(bus.sram_addr), 32'(a[AW-1:0]));
          chk("sram_byteen", 32'(bus.sram_byteen), 32'(be));
          chk("sram_wdata", bus.sram_wdata, d);
        end
      end
      if (done_of(p)) begin
        seen = 1;
        chk("latency", 32'(c), 32'(exp_lat));
        chk("rdata", data_of(p), exp_data);
        chk("bus_err", 32'(bus.bus_err), 32'(exp_err));
      end else if (bus.bus_err) begin
        ebad = 1;
      end
    end
    bus.mmio_ready = 1'b0;
    chk("done_seen", 32'(seen), 32'd1);
    chk("wrong_port_done", 32'(dbl), 32'd0);
    chk("strobe_window", 32'(vbad), 32'd0);
    chk("bus_err_early", 32'(ebad), 32'd0);
    drive(p, 1'b0, 30'h0, 4'h0, 32'h0);
    tick();
    chk("done_one_cycle", 32'(done_of(p)), 32'd0);
    chk("data_hold", data_of(p), exp_data);
    chk("other_hold", data_of(1 - p), other_before);
    chk("bus_err_pulse", 32'(bus.bus_err), 32'd0);
  endtask

  initial begin
    logic [29:0] ca [2];
    logic [29:0] ra;
    logic [3:0]  rbe;
    int          ng;
    int          c;
    int          last;
    int          kind;
    int          p;
    bit          dbl;
    bit          quiet;

    drive(0, 1'b0, 30'h0, 4'h0, 32'h0);
    drive(1, 1'b0, 30'h0, 4'h0, 32'h0);
    bus.mmio_ready = 1'b0;
    bus.mmio_rdata = 32'h0;
    repeat (3) tick();
    chk("rst_done0", 32'(bus.mem2dc_done0), 32'd0);
    chk("rst_done1", 32'(bus.mem2dc_done1), 32'd0);
    chk("rst_sram_en", 32'(bus.sram_en), 32'd0);
    chk("rst_mmio_valid", 32'(bus.mmio_valid), 32'd0);
    chk("rst_bus_err", 32'(bus.bus_err), 32'd0);
    chk("rst_data_in0", bus.mem2dc_data_in0, 32'h0);
    chk("rst_data_in1", bus.mem2dc_data_in1, 32'h0);
    chk("rst_mmio_addr", 32'(bus.mmio_addr), 32'h0);
    rst = 1'b0;
    tick();

    // SRAM write then read, byte write, and address wrap.
    do_req(0, 30'h0000_0010, 4'hF, 32'h1234_5678, 0, 32'h0);
    do_req(0, 30'h0000_0010, 4'h0, 32'h0, 0, 32'h0);
    do_req(1, 30'h0000_0010, 4'b0010, 32'h0000_AA00, 0, 32'h0);
    do_req(1, 30'h0000_0010, 4'h0, 32'h0, 0, 32'h0);
    do_req(0, 30'h1FFF_C010, 4'h0, 32'h0, 0, 32'h0);
    do_req(1, 30'h1FFF_C011, 4'b1001, 32'h5A00_00A5, 0, 32'h0);
    do_req(0, 30'h0000_0011, 4'h0, 32'h0, 0, 32'h0);

    // Contention: both ports keep a read pending at all times.
    ca[0] = 30'(32'h10); ca[1] = 30'(32'h11);
    drive(0, 1'b1, ca[0], 4'h0, 32'h0);
    drive(1, 1'b1, ca[1], 4'h0, 32'h0);
    ng = 0; c = 0; last = 0; dbl = 0;
    while (ng < 10 && c < 100) begin
      tick();
      c++;
      if (bus.mem2dc_done0 && bus.mem2dc_done1) dbl = 1;
      for (int q = 0; q < 2; q++) begin
        if (done_of(q)) begin
          chk("cont_order", 32'(q), 32'((ng % (SL + 1)) == SL));
          chk("cont_data", data_of(q), ref_mem[int'(ca[q][AW-1:0])]);
          chk("cont_spacing", 32'(c - last), (ng == 0) ? 32'd3 : 32'd4);
          last = c;
          ng++;
          ca[q] = 30'($urandom_range(0, 31));
          drive(q, 1'b1, ca[q], 4'h0, 32'h0);
        end
      end
    end
    chk("cont_count", 32'(ng), 32'd10);
    chk("cont_single_done", 32'(dbl), 32'd0);
    drive(0, 1'b0, 30'h0, 4'h0, 32'h0);
    drive(1, 1'b0, 30'h0, 4'h0, 32'h0);
    tick();

    // MMIO stall, immediate-ready write, and timeout.
    do_req(0, 30'h2000_0004, 4'h0, 32'h0, 6, 32'hCAFE_F00D);
    do_req(1, 30'h2000_0008, 4'hF, 32'h0BAD_BEEF, 0, 32'h1111_2222);
    do_req(1, 30'h2000_000C, 4'h0, 32'h0, -1, 32'h0);

    // Reset while an MMIO access is stalled.
    do_req(0, 30'h0000_0010, 4'h0, 32'h0, 0, 32'h0);
    drive(1, 1'b1, 30'h2000_0100, 4'h0, 32'h0);
    repeat (5) tick();
    chk("rst_pre_valid", 32'(bus.mmio_valid), 32'd1);
    rst = 1'b1;
    tick();
    chk("mrst_mmio_valid", 32'(bus.mmio_valid), 32'd0);
    chk("mrst_mmio_addr", 32'(bus.mmio_addr), 32'h0);
    chk("mrst_done0", 32'(bus.mem2dc_done0), 32'd0);
    chk("mrst_done1", 32'(bus.mem2dc_done1), 32'd0);
    chk("mrst_bus_err", 32'(bus.bus_err), 32'd0);
    chk("mrst_sram_en", 32'(bus.sram_en), 32'd0);
    chk("mrst_sram_addr", 32'(bus.sram_addr), 32'h0);
    chk("mrst_data_in0", bus.mem2dc_data_in0, 32'h0);
    chk("mrst_data_in1", bus.mem2dc_data_in1, 32'h0);
    drive(1, 1'b0, 30'h0, 4'h0, 32'h0);
    rst = 1'b0;
    quiet = 1;
    repeat (4) begin
      tick();
      if (bus.mem2dc_done0 || bus.mem2dc_done1 || bus.mmio_valid || bus.sram_en) quiet = 0;
    end
    chk("mrst_quiet", 32'(quiet), 32'd1);
    do_req(1, 30'h2000_0200, 4'h0, 32'h0, 2, 32'h0BAD_CAFE);
    do_req(0, 30'h0000_0010, 4'h0, 32'h0, 0, 32'h0);

    // Randomized single-port traffic over a small aliased address window.
    for (int i = 0; i < 24; i++) begin
      p    = int'($urandom_range(0, 1));
      kind = int'($urandom_range(0, 3));
      rbe  = (kind == 0 || kind == 3) ? 4'($urandom_range(1, 15)) : 4'h0;
      if (kind < 2 || kind == 3 && ($urandom_range(0, 1) == 0)) begin
        ra = {1'b0, 15'($urandom), 14'($urandom_range(0, 15))};
        do_req(p, ra, rbe, $urandom, 0, 32'h0);
      end else begin
        ra = {1'b1, 29'($urandom)};
        do_req(p, ra, rbe, $urandom, int'($urandom_range(0, 10)), $urandom);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
